// File: rtl/memory_burst.sv
// rtl/memory_burst.sv - single-port burst memory slave with valid/ready beats,
// byte strobes, programmable wait states and start-address error reporting.
module memory_burst #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 64,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int LEN_WIDTH   = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  wt_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH/8-1:0]    wstrb,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  err
);

  localparam int NB    = WIDTH / 8;
  localparam int WS_M1 = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

  state_t                state_q, state_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [3:0]            wait_q, wait_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    ready   = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          wr_d    = wt_rd;
          addr_d  = addr;
          len_d   = burst_len;
          beat_d  = '0;
          err_d   = ({1'b0, addr} >= DEPTH_W);
          wait_d  = 4'(WS_M1);
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_BEAT;
        end
      end
      S_WAIT: begin
        if (!valid)            state_d = S_IDLE;
        else if (wait_q == '0) state_d = S_BEAT;
        else                   wait_d  = wait_q - 4'd1;
      end
      S_BEAT: begin
        // An aborted beat (valid low) is not a completed beat, so no ready pulse.
        ready = valid;
        err   = valid & err_q;
        if (!valid || beat_q == len_q) begin
          state_d = S_IDLE;
        end else begin
          beat_d  = beat_q + 1'b1;
          addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          wait_d  = 4'(WS_M1);
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_BEAT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Read data is captured on every entry into BEAT so it is stable for the whole ready cycle.
    if (state_d == S_BEAT && !wr_d) rdata_d = err_d ? '0 : mem[addr_d];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_BEAT && valid && wr_q && !err_q) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) mem[addr_q][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule
